// File: rtl/hbridge_pkg.sv
// Shared encodings for the multi-channel H-bridge controller: drive modes,
// leg FSM states and the per-leg request code.
package hbridge_pkg;

    typedef enum logic [1:0] {
        MODE_COAST   = 2'd0,
        MODE_LAP     = 2'd1,
        MODE_SIGNMAG = 2'd2,
        MODE_BRAKE   = 2'd3
    } mode_e;

    localparam logic [1:0] LEG_OFF  = 2'd0;
    localparam logic [1:0] LEG_HI   = 2'd1;
    localparam logic [1:0] LEG_LO   = 2'd2;
    localparam logic [1:0] LEG_DEAD = 2'd3;

    localparam logic [1:0] REQ_OFF = 2'd0;
    localparam logic [1:0] REQ_HI  = 2'd1;
    localparam logic [1:0] REQ_LO  = 2'd2;

    function automatic logic [1:0] pwm_req(input logic pwm);
        return pwm ? REQ_HI : REQ_LO;
    endfunction

    function automatic logic [1:0] req_to_leg(input logic [1:0] req);
        logic [1:0] st;
        case (req)
            REQ_HI:  st = LEG_HI;
            REQ_LO:  st = LEG_LO;
            default: st = LEG_OFF;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/hbridge_leg.sv
// One half-bridge leg: break-before-make FSM with a programmable dead timer.
// A leg never turns a FET on without passing through DEAD when dead_time > 0.
module hbridge_leg
    import hbridge_pkg::*;
#(
    parameter int DWID = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req,
    input  logic [DWID-1:0] dead_time,
    input  logic            force_off,
    output logic            top,
    output logic            bot
);

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [1:0]      target_s;
    logic [DWID-1:0] timer_r;
    logic [DWID-1:0] timer_nxt_s;
    logic            top_r;
    logic            bot_r;

    // Next-state and dead-timer decision; the target is re-read at dead expiry
    always_comb begin
        target_s    = force_off ? LEG_OFF : req_to_leg(req);
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        case (state_r)
            LEG_OFF, LEG_HI, LEG_LO: begin
                if (target_s == LEG_OFF) begin
                    state_nxt_s = LEG_OFF;
                end else if (target_s == state_r) begin
                    state_nxt_s = state_r;
                end else if (dead_time == '0) begin
                    state_nxt_s = target_s;
                end else begin
                    state_nxt_s = LEG_DEAD;
                    timer_nxt_s = dead_time - DWID'(1);
                end
            end
            LEG_DEAD: begin
                if (target_s == LEG_OFF) begin
                    state_nxt_s = LEG_OFF;
                end else if (timer_r == '0) begin
                    state_nxt_s = target_s;
                end else begin
                    timer_nxt_s = timer_r - DWID'(1);
                end
            end
            default: begin
                state_nxt_s = LEG_OFF;
                timer_nxt_s = '0;
            end
        endcase
    end

    // State, timer and gate registers; gates are decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LEG_OFF;
            timer_r <= '0;
            top_r   <= 1'b0;
            bot_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            top_r   <= (state_nxt_s == LEG_HI);
            bot_r   <= (state_nxt_s == LEG_LO);
        end
    end

    assign top = top_r;
    assign bot = bot_r;

endmodule

// File: rtl/hbridge_multi.sv
// NCH-channel H-bridge controller: shared PWM counter, per-channel shadowed
// duty/mode/direction, per-leg dead time and a sticky synchronised fault.
module hbridge_multi
    import hbridge_pkg::*;
#(
    parameter int DWID    = 32,
    parameter int NCH     = 4,
    parameter int SYNC_FF = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_enable,
    input  logic [NCH-1:0]      i_pn,
    input  logic [DWID-1:0]     i_period,
    input  logic [NCH*DWID-1:0] i_hi_time,
    input  logic [NCH*2-1:0]    i_mode,
    input  logic [NCH-1:0]      i_dir,
    input  logic [DWID-1:0]     i_dead_time,
    input  logic                i_fault_n,
    input  logic                i_fault_clr,
    output logic                o_sync,
    output logic                o_fault,
    output logic [NCH-1:0]      o_q_tl,
    output logic [NCH-1:0]      o_q_bl,
    output logic [NCH-1:0]      o_q_tr,
    output logic [NCH-1:0]      o_q_br
);

    logic [DWID-1:0]           cnt_r;
    logic                      run_s;
    logic                      load_s;
    logic                      wrap_s;
    logic [NCH-1:0][DWID-1:0]  duty_r;
    logic [NCH-1:0][1:0]       mode_r;
    logic [NCH-1:0]            dir_r;
    logic [NCH-1:0][DWID-1:0]  duty_eff_s;
    logic [NCH-1:0][1:0]       mode_eff_s;
    logic [NCH-1:0]            dir_eff_s;
    logic [NCH-1:0]            pwm_r;
    logic [NCH-1:0][1:0]       pmode_r;
    logic [NCH-1:0]            pdir_r;
    logic                      sync_r;
    logic [SYNC_FF-1:0]        fsync_r;
    logic                      fault_r;
    logic                      fault_set_s;
    logic                      force_off_s;
    logic [NCH-1:0][1:0]       req_l_s;
    logic [NCH-1:0][1:0]       req_r_s;
    logic [NCH-1:0]            lt_s;
    logic [NCH-1:0]            lb_s;
    logic [NCH-1:0]            rt_s;
    logic [NCH-1:0]            rb_s;

    assign run_s  = i_enable && (i_period != '0);
    assign wrap_s = (cnt_r >= (i_period - DWID'(1)));
    assign load_s = run_s && (cnt_r == '0);

    // Period counter; a shrunk period is caught by the >= compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!run_s || wrap_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + DWID'(1);
        end
    end

    // At period start the fresh inputs are used directly so the new duty covers cnt==0
    always_comb begin
        duty_eff_s = load_s ? i_hi_time : duty_r;
        mode_eff_s = load_s ? i_mode    : mode_r;
        dir_eff_s  = load_s ? i_dir     : dir_r;
    end

    // Shadow registers and the pwm/mode pipeline stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r  <= '0;
            mode_r  <= '0;
            dir_r   <= '0;
            pwm_r   <= '0;
            pmode_r <= '0;
            pdir_r  <= '0;
            sync_r  <= 1'b0;
        end else begin
            duty_r  <= duty_eff_s;
            mode_r  <= mode_eff_s;
            dir_r   <= dir_eff_s;
            pmode_r <= mode_eff_s;
            pdir_r  <= dir_eff_s;
            sync_r  <= load_s;
            for (int k = 0; k < NCH; k++) begin
                pwm_r[k] <= (cnt_r < duty_eff_s[k]);
            end
        end
    end

    assign fault_set_s = ~fsync_r[SYNC_FF-1];
    assign force_off_s = fault_r | fault_set_s | ~run_s;

    // Fault synchroniser and sticky latch; an active fault beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsync_r <= '1;
            fault_r <= 1'b0;
        end else begin
            fsync_r <= {fsync_r[SYNC_FF-2:0], i_fault_n};
            if (fault_set_s) begin
                fault_r <= 1'b1;
            end else if (i_fault_clr) begin
                fault_r <= 1'b0;
            end else begin
                fault_r <= fault_r;
            end
        end
    end

    // Mode decode into left/right leg requests
    always_comb begin
        req_l_s = '0;
        req_r_s = '0;
        for (int k = 0; k < NCH; k++) begin
            case (pmode_r[k])
                MODE_LAP: begin
                    req_l_s[k] = pwm_req(pwm_r[k]);
                    req_r_s[k] = pwm_req(~pwm_r[k]);
                end
                MODE_SIGNMAG: begin
                    if (pdir_r[k]) begin
                        req_l_s[k] = REQ_LO;
                        req_r_s[k] = pwm_req(pwm_r[k]);
                    end else begin
                        req_l_s[k] = pwm_req(pwm_r[k]);
                        req_r_s[k] = REQ_LO;
                    end
                end
                MODE_BRAKE: begin
                    req_l_s[k] = REQ_LO;
                    req_r_s[k] = REQ_LO;
                end
                default: begin
                    req_l_s[k] = REQ_OFF;
                    req_r_s[k] = REQ_OFF;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        hbridge_leg #(.DWID(DWID)) u_left (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req_l_s[k]),
            .dead_time (i_dead_time),
            .force_off (force_off_s),
            .top       (lt_s[k]),
            .bot       (lb_s[k])
        );
        hbridge_leg #(.DWID(DWID)) u_right (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req_r_s[k]),
            .dead_time (i_dead_time),
            .force_off (force_off_s),
            .top       (rt_s[k]),
            .bot       (rb_s[k])
        );
    end

    // P-channel top FETs are on when their gate is low
    assign o_q_tl  = lt_s ^ i_pn;
    assign o_q_tr  = rt_s ^ i_pn;
    assign o_q_bl  = lb_s;
    assign o_q_br  = rb_s;
    assign o_sync  = sync_r;
    assign o_fault = fault_r;

endmodule

// File: tb/tb_hbridge_multi.sv
// Randomised and directed bench for hbridge_multi with a cycle-level reference
// model feeding an expectation queue that a separate monitor drains.
module tb_hbridge_multi;

    localparam int DWID    = 32;
    localparam int NCH     = 2;
    localparam int SYNC_FF = 2;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic [NCH-1:0]      pn;
    logic [DWID-1:0]     period;
    logic [NCH*DWID-1:0] hi;
    logic [NCH*2-1:0]    mode;
    logic [NCH-1:0]      dir;
    logic [DWID-1:0]     dead;
    logic                fault_n;
    logic                fault_clr;
    logic                o_sync;
    logic                o_fault;
    logic [NCH-1:0]      o_q_tl;
    logic [NCH-1:0]      o_q_bl;
    logic [NCH-1:0]      o_q_tr;
    logic [NCH-1:0]      o_q_br;

    hbridge_multi #(.DWID(DWID), .NCH(NCH), .SYNC_FF(SYNC_FF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (en),
        .i_pn        (pn),
        .i_period    (period),
        .i_hi_time   (hi),
        .i_mode      (mode),
        .i_dir       (dir),
        .i_dead_time (dead),
        .i_fault_n   (fault_n),
        .i_fault_clr (fault_clr),
        .o_sync      (o_sync),
        .o_fault     (o_fault),
        .o_q_tl      (o_q_tl),
        .o_q_bl      (o_q_bl),
        .o_q_tr      (o_q_tr),
        .o_q_br      (o_q_br)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // ---------------- reference model (leg drive: 0 off, 1 top, 2 bottom) ----------------
    typedef logic [2+4*NCH-1:0] obs_t;
    obs_t exp_q[$];

    int m_cnt;
    int m_duty[NCH];
    int m_mode[NCH];
    int m_dir[NCH];
    bit m_pwm[NCH];
    int m_pmode[NCH];
    int m_pdir[NCH];
    bit m_sync;
    bit m_fault;
    bit m_fs[SYNC_FF];
    int m_drv[2*NCH];
    int m_dl[2*NCH];

    task automatic model_reset();
        m_cnt = 0; m_sync = 0; m_fault = 0;
        for (int k = 0; k < NCH; k++) begin
            m_duty[k] = 0; m_mode[k] = 0; m_dir[k] = 0;
            m_pwm[k] = 0; m_pmode[k] = 0; m_pdir[k] = 0;
        end
        for (int i = 0; i < SYNC_FF; i++) m_fs[i] = 1'b1;
        for (int j = 0; j < 2*NCH; j++) begin
            m_drv[j] = 0; m_dl[j] = 0;
        end
    endtask

    // Leg requests from mode: 1 LAP, 2 SIGNMAG, 3 BRAKE, otherwise coast
    function automatic void leg_req(input bit p, input int md, input int dr, output int l, output int r);
        int d;
        d = p ? 1 : 2;
        l = 0; r = 0;
        case (md)
            1: begin l = d; r = p ? 2 : 1; end
            2: begin
                if (dr == 0) begin l = d; r = 2; end
                else begin l = 2; r = d; end
            end
            3: begin l = 2; r = 2; end
            default: begin l = 0; r = 0; end
        endcase
    endfunction

    task automatic model_step();
        bit run, load, fset, off;
        int rq[2*NCH];
        run  = en && (period != 0);
        load = run && (m_cnt == 0);
        fset = !m_fs[SYNC_FF-1];
        off  = m_fault || fset || !run;
        for (int k = 0; k < NCH; k++) leg_req(m_pwm[k], m_pmode[k], m_pdir[k], rq[2*k], rq[2*k+1]);
        for (int j = 0; j < 2*NCH; j++) begin
            if (off || rq[j] == 0) begin
                m_drv[j] = 0; m_dl[j] = 0;
            end else if (m_dl[j] > 0) begin
                m_dl[j]--;
                if (m_dl[j] == 0) m_drv[j] = rq[j];
            end else if (m_drv[j] != rq[j]) begin
                if (dead == 0) m_drv[j] = rq[j];
                else begin m_drv[j] = 0; m_dl[j] = int'(dead); end
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (load) begin
                m_duty[k] = int'(hi[k*DWID +: DWID]);
                m_mode[k] = int'(mode[k*2 +: 2]);
                m_dir[k]  = int'(dir[k]);
            end
            m_pwm[k]   = (m_cnt < m_duty[k]);
            m_pmode[k] = m_mode[k];
            m_pdir[k]  = m_dir[k];
        end
        m_sync = load;
        if (!run) m_cnt = 0;
        else if (m_cnt >= int'(period) - 1) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        m_fault = fset ? 1'b1 : (fault_clr ? 1'b0 : m_fault);
        for (int i = SYNC_FF-1; i > 0; i--) m_fs[i] = m_fs[i-1];
        m_fs[0] = fault_n;
    endtask

    function automatic obs_t model_obs();
        logic [NCH-1:0] tl, bl, tr, br;
        for (int k = 0; k < NCH; k++) begin
            tl[k] = (m_drv[2*k] == 1) ^ pn[k];
            bl[k] = (m_drv[2*k] == 2);
            tr[k] = (m_drv[2*k+1] == 1) ^ pn[k];
            br[k] = (m_drv[2*k+1] == 2);
        end
        return {m_sync, m_fault, tl, bl, tr, br};
    endfunction

    // Scoreboard producer: advances the model on every clock edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_step();
                exp_q.push_back(model_obs());
            end
        end
    end

    // Monitor: compares DUT pins against the queued expectation mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && exp_q.size() > 0) begin
                obs_t e;
                e = exp_q.pop_front();
                check("outputs", {o_sync, o_fault, o_q_tl, o_q_bl, o_q_tr, o_q_br}, e);
            end
            check("shoot_through", ((o_q_tl ^ pn) & o_q_bl) | ((o_q_tr ^ pn) & o_q_br), 0);
        end
    end

    // ---------------- directed helpers ----------------
    int c_tl0, c_bl0, c_tl1, c_bl1, c_tr1, c_br1, c_sync;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sync();
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = o_sync;
        end
        check("sync_timeout", seen, 1);
    endtask

    task automatic count_window(input int n, input int chg_at, input logic [DWID-1:0] chg_val);
        c_tl0 = 0; c_bl0 = 0; c_tl1 = 0; c_bl1 = 0; c_tr1 = 0; c_br1 = 0; c_sync = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c_tl0 += int'(o_q_tl[0]); c_bl0 += int'(o_q_bl[0]);
            c_tl1 += int'(o_q_tl[1]); c_bl1 += int'(o_q_bl[1]);
            c_tr1 += int'(o_q_tr[1]); c_br1 += int'(o_q_br[1]);
            c_sync += int'(o_sync);
            if (i == chg_at) begin
                #1;
                hi[DWID-1:0] = chg_val;
            end
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_tl"}, o_q_tl, pn);
        check({tag, "_tr"}, o_q_tr, pn);
        check({tag, "_bl_br"}, {o_q_bl, o_q_br}, 0);
        check({tag, "_sync_fault"}, {o_sync, o_fault}, 0);
    endtask

    initial begin
        logic [DWID-1:0] v;
        bit found;
        rst_n = 1'b0; en = 1'b0; pn = 2'b10; period = '0; hi = '0; mode = '0;
        dir = '0; dead = '0; fault_n = 1'b1; fault_clr = 1'b0;
        repeat (3) tick();
        check_reset_pins("reset");
        rst_n = 1'b1;
        pn = 2'b00;

        // ch0 LAP 50/100 and ch1 SIGNMAG right-leg 25/100, dead time 4
        period = 32'd100; dead = 32'd4; mode = 4'b10_01; dir = 2'b10;
        hi = {32'd25, 32'd50}; en = 1'b1;
        repeat (250) tick();
        wait_sync();
        count_window(100, -1, '0);
        check("lap_tl0_high", c_tl0, 46);
        check("lap_bl0_high", c_bl0, 46);
        check("sync_per_period", c_sync, 1);
        check("sm_tr1_high", c_tr1, 21);
        check("sm_br1_high", c_br1, 71);
        check("sm_bl1_const", c_bl1, 100);
        check("sm_tl1_off", c_tl1, 0);

        // duty change mid-period is invisible until the next wrap
        hi[DWID-1:0] = 32'd20;
        repeat (250) tick();
        wait_sync();
        count_window(100, 40, 32'd80);
        check("shadow_old_duty", c_tl0, 16);
        count_window(100, -1, '0);
        check("shadow_new_duty", c_tl0, 76);

        // one-cycle fault pulse: gates off after SYNC_FF+1 edges, sticky
        tick(); fault_n = 1'b0;
        tick(); fault_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("fault_gates_off", {o_q_tl ^ pn, o_q_bl, o_q_tr ^ pn, o_q_br}, 0);
        check("fault_set", o_fault, 1);
        repeat (10) tick();
        check("fault_sticky", o_fault, 1);
        fault_n = 1'b0;
        repeat (3) tick();
        fault_clr = 1'b1;
        tick(); fault_clr = 1'b0;
        repeat (2) tick();
        check("clear_ignored", o_fault, 1);
        fault_n = 1'b1;
        repeat (4) tick();
        fault_clr = 1'b1;
        tick(); fault_clr = 1'b0;
        check("fault_cleared", o_fault, 0);

        // dead=0 boundaries: duty 0 -> constant LO, duty=period -> constant HI
        dead = '0; hi[DWID-1:0] = '0;
        repeat (210) tick();
        count_window(100, -1, '0);
        check("duty0_bl0", c_bl0, 100);
        check("duty0_tl0", c_tl0, 0);
        hi[DWID-1:0] = 32'd100;
        repeat (210) tick();
        count_window(100, -1, '0);
        check("duty100_tl0", c_tl0, 100);
        check("duty100_bl0", c_bl0, 0);
        pn = 2'b01;
        repeat (3) tick();
        count_window(100, -1, '0);
        check("pn_tl0_inverted", c_tl0, 0);

        // asynchronous reset while a leg sits in dead time
        pn = 2'b00; dead = 32'd4; hi[DWID-1:0] = 32'd50;
        repeat (5) tick();
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            found = (o_q_tl[0] == pn[0]) && (o_q_bl[0] == 1'b0) && (o_fault == 1'b0);
        end
        check("dead_timeout", found, 1);
        #1 rst_n = 1'b0;
        #1 check_reset_pins("async_reset");
        tick(); tick();
        rst_n = 1'b1;

        // randomised phases checked by the model
        for (int ph = 0; ph < 30; ph++) begin
            tick();
            period = ($urandom_range(0, 9) == 0) ? '0 : DWID'($urandom_range(1, 40));
            dead = DWID'($urandom_range(0, 5));
            pn = NCH'($urandom);
            en = ($urandom_range(0, 7) != 0);
            mode = 4'($urandom);
            dir = NCH'($urandom);
            for (int k = 0; k < NCH; k++) hi[k*DWID +: DWID] = DWID'($urandom_range(0, int'(period) + 3));
            repeat ($urandom_range(30, 150)) begin
                int r;
                tick();
                r = int'($urandom_range(0, 99));
                fault_n = ($urandom_range(0, 199) != 0);
                fault_clr = ($urandom_range(0, 19) == 0);
                if (r < 6) begin
                    v = DWID'($urandom_range(0, int'(period) + 3));
                    hi[($urandom_range(0, NCH-1))*DWID +: DWID] = v;
                end else if (r < 9) mode = 4'($urandom);
                else if (r < 10) dir = NCH'($urandom);
                else if (r == 20) en = ~en;
                else if (r == 21) period = DWID'($urandom_range(1, 40));
                else if (r == 22) dead = DWID'($urandom_range(0, 5));
                else if (r == 23 && $urandom_range(0, 3) == 0) begin
                    rst_n = 1'b0;
                    #2 rst_n = 1'b1;
                end else if (r == 24) pn = NCH'($urandom);
            end
            fault_n = 1'b1;
        end
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
